// File: rtl/branch_resolution_queue.sv
// In-flight branch queue: holds predictions until resolution, emits PHT update
// strobes, and on a mispredict flushes everything and replays a GHR rollback.
module branch_resolution_queue #(
  parameter int HISTORY_LEN = 8,
  parameter int DEPTH       = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pred_valid,
  input  logic [15:0]            pred_pc,
  input  logic [HISTORY_LEN-1:0] pred_history,
  input  logic                   pred_taken,
  output logic                   pred_ready,
  input  logic                   res_valid,
  input  logic                   res_taken,
  output logic                   res_ready,
  output logic                   upd_write_enabled,
  output logic [15:0]            upd_pc,
  output logic                   upd_outcome,
  output logic [HISTORY_LEN-1:0] upd_history,
  output logic                   upd_rollback_enabled,
  output logic                   mispredict,
  output logic                   overflow_err
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE = 1'b0, ROLLBACK = 1'b1} state_e;

  typedef struct packed {
    logic [15:0]            pc;
    logic [HISTORY_LEN-1:0] hist;
    logic                   taken;
  } entry_t;

  entry_t                 mem [DEPTH];
  entry_t                 head_e;
  logic [AW-1:0]          head_q, tail_q;
  logic [AW:0]            count_q;
  logic [HISTORY_LEN-1:0] rb_hist_q;
  state_e                 state_q, state_d;
  logic                   push, pop, mis;

  assign head_e = mem[head_q];

  // Readies are gated by reset so they read 0 while held in reset.
  assign pred_ready = reset && (state_q == IDLE) && (count_q < (AW+1)'(DEPTH));
  assign res_ready  = reset && (state_q == IDLE) && (count_q != '0);

  assign push = pred_valid && pred_ready;
  assign pop  = res_valid && res_ready;
  assign mis  = pop && (res_taken != head_e.taken);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (mis) state_d = ROLLBACK;
      ROLLBACK: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push && !mis) mem[tail_q] <= '{pc: pred_pc, hist: pred_history, taken: pred_taken};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q              <= IDLE;
      head_q               <= '0;
      tail_q               <= '0;
      count_q              <= '0;
      rb_hist_q            <= '0;
      upd_write_enabled    <= 1'b0;
      upd_pc               <= '0;
      upd_outcome          <= 1'b0;
      upd_history          <= '0;
      upd_rollback_enabled <= 1'b0;
      mispredict           <= 1'b0;
      overflow_err         <= 1'b0;
    end else begin
      state_q              <= state_d;
      upd_write_enabled    <= pop;
      upd_pc               <= pop ? head_e.pc : '0;
      upd_outcome          <= pop & res_taken;
      upd_history          <= pop ? head_e.hist :
                              (state_q == ROLLBACK) ? rb_hist_q : '0;
      upd_rollback_enabled <= (state_q == ROLLBACK);
      mispredict           <= mis;
      if (mis) rb_hist_q <= {head_e.hist[HISTORY_LEN-2:0], res_taken};
      // Refusal while IDLE can only mean the queue is full.
      if (pred_valid && !pred_ready && (state_q == IDLE)) overflow_err <= 1'b1;
      if (mis) begin
        head_q  <= tail_q;
        count_q <= '0;
      end else begin
        if (push) tail_q <= tail_q + AW'(1);
        if (pop)  head_q <= head_q + AW'(1);
        count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
      end
    end
  end
endmodule

// File: tb/tb_branch_resolution_queue.sv
// Random + directed bench for branch_resolution_queue against a queue-based model.
module tb_branch_resolution_queue;
  localparam int HL = 8;
  localparam int DP = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          pred_valid = 1'b0, pred_taken = 1'b0, res_valid = 1'b0, res_taken = 1'b0;
  logic [15:0]   pred_pc = '0;
  logic [HL-1:0] pred_history = '0;
  logic          pred_ready, res_ready, upd_write_enabled, upd_outcome;
  logic          upd_rollback_enabled, mispredict, overflow_err;
  logic [15:0]   upd_pc;
  logic [HL-1:0] upd_history;

  always #5 clk = ~clk;

  branch_resolution_queue #(.HISTORY_LEN(HL), .DEPTH(DP)) dut (
    .clk(clk), .reset(reset),
    .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_history(pred_history),
    .pred_taken(pred_taken), .pred_ready(pred_ready),
    .res_valid(res_valid), .res_taken(res_taken), .res_ready(res_ready),
    .upd_write_enabled(upd_write_enabled), .upd_pc(upd_pc), .upd_outcome(upd_outcome),
    .upd_history(upd_history), .upd_rollback_enabled(upd_rollback_enabled),
    .mispredict(mispredict), .overflow_err(overflow_err)
  );

  typedef struct {
    logic [15:0]   pc;
    logic [HL-1:0] h;
    logic          t;
  } ent_t;

  ent_t          mq[$];
  bit            m_rb;
  logic [HL-1:0] m_rbh;
  logic          e_we, e_out, e_rb, e_mis, e_ovf;
  logic [15:0]   e_pc;
  logic [HL-1:0] e_hist;
  int            n_tot = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    mq.delete();
    m_rb = 0; m_rbh = '0;
    e_we = 0; e_pc = '0; e_out = 0; e_hist = '0; e_rb = 0; e_mis = 0; e_ovf = 0;
  endtask

  task automatic chk_outs();
    chk("upd_we", upd_write_enabled, e_we);
    chk("upd_pc", upd_pc, e_pc);
    chk("upd_outcome", upd_outcome, e_out);
    chk("upd_history", upd_history, e_hist);
    chk("rollback", upd_rollback_enabled, e_rb);
    chk("mispredict", mispredict, e_mis);
    chk("overflow", overflow_err, e_ovf);
  endtask

  // One clock: drive at negedge, check readies, advance model, check outputs after edge.
  task automatic step(input logic pv, input logic [15:0] pc, input logic [HL-1:0] ph,
                      input logic pt, input logic rv, input logic rt);
    bit prdy, rrdy, push, pop, mis;
    ent_t e;
    @(negedge clk);
    pred_valid = pv; pred_pc = pc; pred_history = ph; pred_taken = pt;
    res_valid = rv; res_taken = rt;
    prdy = !m_rb && (mq.size() < DP);
    rrdy = !m_rb && (mq.size() > 0);
    #1;
    chk("pred_ready", pred_ready, prdy);
    chk("res_ready", res_ready, rrdy);
    push = pv && prdy;
    pop  = rv && rrdy;
    mis  = 0;
    e_we = 0; e_pc = '0; e_out = 0; e_hist = '0; e_rb = 0; e_mis = 0;
    if (m_rb) begin e_rb = 1; e_hist = m_rbh; end
    if (pv && !m_rb && mq.size() == DP) e_ovf = 1;
    if (pop) begin
      e = mq.pop_front();
      e_we = 1; e_pc = e.pc; e_out = rt; e_hist = e.h;
      mis = (rt != e.t); e_mis = mis;
    end
    m_rb = mis;
    if (mis) begin
      m_rbh = {e.h[HL-2:0], rt};
      mq.delete();
    end else if (push) begin
      mq.push_back('{pc, ph, pt});
    end
    @(posedge clk); #1;
    chk_outs();
    pred_valid = 0; res_valid = 0;
  endtask

  initial begin
    logic rt;
    m_reset();
    #12;
    chk_outs();
    chk("rst_pred_ready", pred_ready, 0);
    chk("rst_res_ready", res_ready, 0);
    @(negedge clk); reset = 1; #1;
    chk("ready_after_rst", pred_ready, 1);

    // Correct prediction: update only.
    step(1, 16'h0040, 8'hA5, 1, 0, 0);
    step(0, 16'h0, 8'h0, 0, 1, 1);
    chk("d1_pc", upd_pc, 32'h40);
    chk("d1_hist", upd_history, 32'hA5);
    chk("d1_mis", mispredict, 0);

    // Mispredict of oldest with two younger entries: flush + rollback.
    step(1, 16'h0100, 8'h3C, 1, 0, 0);
    step(1, 16'h0104, 8'h11, 0, 0, 0);
    step(1, 16'h0108, 8'h22, 1, 0, 0);
    step(0, 16'h0, 8'h0, 0, 1, 0);
    chk("d2_mis", mispredict, 1);
    chk("d2_hist", upd_history, 32'h3C);
    step(1, 16'h0200, 8'h00, 1, 1, 1);
    chk("d2_rb", upd_rollback_enabled, 1);
    chk("d2_rbhist", upd_history, 32'h78);
    step(0, 16'h0, 8'h0, 0, 0, 0);
    chk("d2_empty", res_ready, 0);

    // Fill, overflow, simultaneous push/pop while full, then wrap.
    for (int i = 0; i < 5; i++) step(1, 16'h0300 + 16'(i), 8'(i), 1, 0, 0);
    chk("d3_ovf", overflow_err, 1);
    for (int i = 0; i < 6; i++) step(1, 16'h0400 + 16'(i), 8'h40 + 8'(i), 1, 1, 1);
    for (int i = 0; i < 4; i++) step(0, 16'h0, 8'h0, 0, 1, 1);
    chk("d3_sticky", overflow_err, 1);

    // Resolve while empty: no update.
    step(0, 16'h0, 8'h0, 0, 1, 1);

    // Reset during rollback.
    step(1, 16'h0500, 8'h81, 0, 0, 0);
    step(0, 16'h0, 8'h0, 0, 1, 1);
    @(negedge clk); reset = 0; #1;
    m_reset();
    chk_outs();
    chk("rstrb_ready", pred_ready, 0);
    @(negedge clk); reset = 1;
    step(0, 16'h0, 8'h0, 0, 0, 0);
    chk("rstrb_norb", upd_rollback_enabled, 0);

    // Random traffic, mostly-correct resolutions so the queue fills.
    for (int i = 0; i < 600; i++) begin
      if (mq.size() > 0 && $urandom_range(0, 99) < 85) rt = mq[0].t;
      else rt = 1'($urandom_range(0, 1));
      step(1'($urandom_range(0, 99) < 60), 16'($urandom), 8'($urandom),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 99) < 45), rt);
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
